// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder: one parallel frame in, one 2-bit
// symbol per clock out (LSB first), followed by K-1 zero tail bits.
`ifndef DATA_FRAME_LENGTH
`define DATA_FRAME_LENGTH 8
`endif
`ifndef MAX_CONSTRAINT_LENGTH
`define MAX_CONSTRAINT_LENGTH 9
`endif

module conv_encoder #(
  parameter int             FRAME_LEN = `DATA_FRAME_LENGTH,
  parameter int             K         = 3,
  parameter logic [K-1:0]   G0        = 3'b111,
  parameter logic [K-1:0]   G1        = 3'b101
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_e,
  input  logic [FRAME_LEN-1:0] i_encoder_data,
  output logic [1:0]           o_encoder_data,
  output logic                 o_encoder_valid,
  output logic                 o_encoder_done,
  output logic                 o_encoder_busy
);

  localparam int CW = $clog2(FRAME_LEN + K);

  // state    | meaning
  // S_IDLE   | waiting for en_e; frame latched and history cleared on start
  // S_ENCODE | one information bit per cycle, LSB of the frame first
  // S_FLUSH  | K-1 zero tail bits drive the trellis back to state 0
  // S_DONE   | one-cycle done pulse, then back to idle
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENCODE = 2'd1,
    S_FLUSH  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               r_state;
  logic [FRAME_LEN-1:0] r_frame;
  logic [K-2:0]         r_sr;
  logic [CW-1:0]        r_cnt;
  logic [1:0]           r_data;
  logic                 r_valid;
  logic                 r_done;
  logic                 r_busy;

  logic                 w_bit;
  logic [K-1:0]         w_win;
  logic [1:0]           w_sym;
  logic [K-2:0]         w_sr_next;

  // The frame register shifts right each ENCODE cycle, so bit 0 is always current.
  always_comb begin
    w_bit = 1'b0;
    if (r_state == S_ENCODE) begin
      w_bit = r_frame[0];
    end
  end

  assign w_win = {w_bit, r_sr};
  assign w_sym = {^(w_win & G0), ^(w_win & G1)};

  generate
    if (K == 2) begin : g_k2
      assign w_sr_next = w_bit;
    end else begin : g_kn
      assign w_sr_next = {w_bit, r_sr[K-2:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_frame <= '0;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_data  <= 2'b00;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (en_e) begin
            r_frame <= i_encoder_data;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ENCODE;
          end
        end
        S_ENCODE: begin
          r_data  <= w_sym;
          r_valid <= 1'b1;
          r_sr    <= w_sr_next;
          r_frame <= r_frame >> 1;
          if (r_cnt == CW'(FRAME_LEN - 1)) begin
            r_cnt   <= '0;
            r_state <= S_FLUSH;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_FLUSH: begin
          r_data  <= w_sym;
          r_valid <= 1'b1;
          r_sr    <= w_sr_next;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(K - 2)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_valid <= 1'b0;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_encoder_data  = r_data;
  assign o_encoder_valid = r_valid;
  assign o_encoder_done  = r_done;
  assign o_encoder_busy  = r_busy;

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: table of frames with expected symbol
// streams, a symbol scoreboard, and hand sequences for multi-cycle corners.
`timescale 1ns/1ps

module tb_conv_encoder;

  logic       clk;
  logic       rst;
  logic       en_e;
  logic [7:0] i_encoder_data;
  logic [1:0] o_encoder_data;
  logic       o_encoder_valid;
  logic       o_encoder_done;
  logic       o_encoder_busy;

  conv_encoder dut (
    .clk             (clk),
    .rst             (rst),
    .en_e            (en_e),
    .i_encoder_data  (i_encoder_data),
    .o_encoder_data  (o_encoder_data),
    .o_encoder_valid (o_encoder_valid),
    .o_encoder_done  (o_encoder_done),
    .o_encoder_busy  (o_encoder_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [19:0] syms;   // first symbol in bits [19:18]
  } vec_t;

  localparam int NVEC = 9;
  localparam logic [19:0] KNOWN_SYMS = 20'b11_10_00_01_01_11_00_00_00_00;

  vec_t       tbl [NVEC];
  logic [1:0] exp_q [$];
  int         n_vec;
  int         n_err;

  int first_valid;
  int done_tick;
  int n_done;
  int n_valid;
  int n_busy;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Independent reference: direct convolution over the padded bit sequence.
  function automatic logic [19:0] model(input logic [7:0] d);
    logic        u [12];
    logic [2:0]  w;
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 12; i++) u[i] = 1'b0;
    for (int t = 0; t < 8; t++) u[t + 2] = d[t];
    for (int t = 0; t < 10; t++) begin
      w = {u[t + 2], u[t + 1], u[t]};
      r[19 - 2*t -: 2] = {^(w & 3'b111), ^(w & 3'b101)};
    end
    return r;
  endfunction

  task automatic push_syms(input logic [19:0] s);
    for (int i = 0; i < 10; i++) exp_q.push_back(s[19 - 2*i -: 2]);
  endtask

  // One cycle: wait for the falling edge and score any valid symbol.
  task automatic tick();
    logic [1:0] e;
    @(negedge clk);
    if (o_encoder_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(o_encoder_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("symbol", 32'(o_encoder_data), 32'(e));
      end
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [19:0] s, input bit glitch);
    i_encoder_data = d;
    en_e           = 1'b1;
    push_syms(s);
    first_valid = 0; done_tick = 0; n_done = 0; n_valid = 0; n_busy = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      tick();
      if (o_encoder_valid) begin
        n_valid++;
        if (first_valid == 0) first_valid = cyc;
      end
      if (o_encoder_busy) n_busy++;
      if (o_encoder_done) begin
        n_done++;
        done_tick = cyc;
      end
      en_e = glitch && (cyc == 4 || cyc == 10);
      if (glitch && cyc == 5) i_encoder_data = ~d;
      if (done_tick != 0) break;
    end
    en_e = 1'b0;
    for (int cyc = 0; cyc < 2; cyc++) begin
      tick();
      if (o_encoder_busy || o_encoder_valid) n_busy += 100;
      if (o_encoder_done) n_done++;
    end
    check("first_valid_cycle", 32'(first_valid), 32'd2);
    check("done_cycle", 32'(done_tick), 32'd12);
    check("done_count", 32'(n_done), 32'd1);
    check("valid_count", 32'(n_valid), 32'd10);
    check("busy_count", 32'(n_busy), 32'd11);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  int t_done1;
  int t_done2;
  int t_valid2;
  logic [7:0] rnd;

  initial begin
    n_vec = 0;
    n_err = 0;
    tbl[0] = '{data: 8'b00001101, syms: KNOWN_SYMS};
    tbl[1] = '{data: 8'h80, syms: 20'b00_00_00_00_00_00_00_11_10_11};
    tbl[2] = '{data: 8'h00, syms: 20'b0};
    tbl[3] = '{data: 8'h01, syms: 20'b11_10_11_00_00_00_00_00_00_00};
    tbl[4] = '{data: 8'hFF, syms: 20'b11_01_10_10_10_10_10_10_01_11};
    for (int i = 5; i < NVEC; i++) begin
      rnd    = 8'($urandom_range(255, 0));
      tbl[i] = '{data: rnd, syms: model(rnd)};
    end

    // Reset state
    rst = 1'b1; en_e = 1'b0; i_encoder_data = 8'h00;
    tick();
    check("rst_data", 32'(o_encoder_data), 32'd0);
    check("rst_valid", 32'(o_encoder_valid), 32'd0);
    check("rst_done", 32'(o_encoder_done), 32'd0);
    check("rst_busy", 32'(o_encoder_busy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_outputs", {o_encoder_data, o_encoder_valid, o_encoder_done, o_encoder_busy}, 32'd0);
    end

    // Table-driven frames
    for (int i = 0; i < NVEC; i++) begin
      run_frame(tbl[i].data, tbl[i].syms, 1'b0);
    end

    // Held last symbol cleared by an asynchronous reset while idle
    run_frame(8'hFF, tbl[4].syms, 1'b0);
    check("data_held", 32'(o_encoder_data), 32'd3);
    #2 rst = 1'b1;
    #1 check("async_rst_idle_data", 32'(o_encoder_data), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("idle_after_rst", {o_encoder_data, o_encoder_valid, o_encoder_done, o_encoder_busy}, 32'd0);

    // Ignored start during ENCODE and FLUSH, data change mid-frame
    run_frame(8'b00001101, KNOWN_SYMS, 1'b1);

    // Back-to-back with en_e held high; data changes mid-frame 1
    i_encoder_data = 8'h00;
    en_e = 1'b1;
    push_syms(20'b0);
    push_syms(KNOWN_SYMS);
    t_done1 = 0; t_done2 = 0; t_valid2 = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (cyc == 5) i_encoder_data = 8'b00001101;
      if (cyc == 13) en_e = 1'b0;
      if (o_encoder_done) begin
        if (t_done1 == 0) t_done1 = cyc;
        else t_done2 = cyc;
      end
      if (o_encoder_valid && t_done1 != 0 && t_valid2 == 0) t_valid2 = cyc;
      if (t_done2 != 0) break;
    end
    en_e = 1'b0;
    check("b2b_done1", 32'(t_done1), 32'd12);
    check("b2b_first_valid2", 32'(t_valid2 - t_done1), 32'd2);
    check("b2b_done2", 32'(t_done2), 32'd24);
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
    tick();
    check("b2b_idle_busy", 32'(o_encoder_busy), 32'd0);

    // Reset mid-frame after the 4th valid symbol
    i_encoder_data = 8'hFF;
    en_e = 1'b1;
    push_syms(tbl[4].syms);
    n_valid = 0;
    for (int cyc = 1; cyc <= 20 && n_valid < 4; cyc++) begin
      tick();
      en_e = 1'b0;
      if (o_encoder_valid) n_valid++;
    end
    check("abort_valid_seen", 32'(n_valid), 32'd4);
    #2 rst = 1'b1;
    #1;
    check("abort_valid", 32'(o_encoder_valid), 32'd0);
    check("abort_busy", 32'(o_encoder_busy), 32'd0);
    check("abort_done", 32'(o_encoder_done), 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    n_done = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      tick();
      if (o_encoder_done || o_encoder_valid || o_encoder_busy) n_done++;
    end
    check("abort_no_activity", 32'(n_done), 32'd0);
    run_frame(8'b00001101, KNOWN_SYMS, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
